// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and load/store requesters onto one single-port memory
// Load/store wins by default; starve_cnt bounds consecutive load/store grants while fetch waits.
module mem_port_arbiter #(
    parameter int MAX_LS_BURST = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    logic        owner_ls;
    logic [3:0]  starve_cnt;
    logic [7:0]  tmo_cnt;
    logic        fetch_starved;
    logic        grant_ls;
    logic        tmo_hit;

    assign fetch_starved = if_req && (starve_cnt == 4'(MAX_LS_BURST));
    assign grant_ls      = ls_req && !fetch_starved;
    assign tmo_hit       = (tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_ls   <= 1'b0;
            starve_cnt <= 4'd0;
            tmo_cnt    <= 8'd0;
            if_ack     <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= 32'd0;
            ls_ack     <= 1'b0;
            ls_err     <= 1'b0;
            ls_rdata   <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        owner_ls  <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= ls_we;
                        mem_be    <= ls_be;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        busy      <= 1'b1;
                        state     <= BUSY;
                        // Only grants that actually make fetch wait count toward the burst.
                        if (!if_req) begin
                            starve_cnt <= 4'd0;
                        end else if (starve_cnt != 4'(MAX_LS_BURST)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (if_req) begin
                        owner_ls   <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= 4'hF;
                        mem_addr   <= if_addr;
                        busy       <= 1'b1;
                        state      <= BUSY;
                        starve_cnt <= 4'd0;
                    end
                end

                BUSY: begin
                    if (mem_rdy || tmo_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                        // A ready arriving on the final timeout cycle still counts as success.
                        if (owner_ls) begin
                            ls_ack <= 1'b1;
                            ls_err <= !mem_rdy;
                            if (mem_rdy) begin
                                ls_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack <= 1'b1;
                            if_err <= !mem_rdy;
                            if (mem_rdy) begin
                                if_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                RESP: begin
                    if_ack  <= 1'b0;
                    if_err  <= 1'b0;
                    ls_ack  <= 1'b0;
                    ls_err  <= 1'b0;
                    tmo_cnt <= 8'd0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        busy;

    logic        auto_rdy;
    logic        rdy_drv;
    int          checks;
    int          errors;

    assign mem_rdy = auto_rdy ? mem_req : rdy_drv;

    mem_port_arbiter #(
        .MAX_LS_BURST(2),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_err(if_err),
        .if_rdata(if_rdata),
        .ls_req(ls_req),
        .ls_we(ls_we),
        .ls_be(ls_be),
        .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_ack(ls_ack),
        .ls_err(ls_err),
        .ls_rdata(ls_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n_grants;
        logic        prev_req;
        logic [5:0]  grant_we;
        logic [5:0]  exp_we;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_be     = 4'd0;
        ls_addr   = 32'd0;
        ls_wdata  = 32'd0;
        mem_rdata = 32'd0;
        rdy_drv   = 1'b0;
        auto_rdy  = 1'b0;
        tick();
        tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Single fetch, zero wait
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("f1_mem_req", {31'd0, mem_req}, 32'd1);
        check("f1_mem_addr", mem_addr, 32'h100);
        check("f1_mem_be", {28'd0, mem_be}, 32'hF);
        check("f1_mem_we", {31'd0, mem_we}, 32'd0);
        rdy_drv = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        check("f1_if_ack", {31'd0, if_ack}, 32'd1);
        check("f1_if_rdata", if_rdata, 32'hDEADBEEF);
        check("f1_if_err", {31'd0, if_err}, 32'd0);
        check("f1_mem_req_resp", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0; rdy_drv = 1'b0;
        tick();
        check("f1_busy_idle", {31'd0, busy}, 32'd0);
        check("f1_ack_pulse", {31'd0, if_ack}, 32'd0);

        // Simultaneous requests: store first, then fetch
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h8000; ls_wdata = 32'h12345678; ls_be = 4'b0011;
        auto_rdy = 1'b1; mem_rdata = 32'h11111111;
        tick();
        check("sim_mem_we", {31'd0, mem_we}, 32'd1);
        check("sim_mem_be", {28'd0, mem_be}, 32'h3);
        check("sim_mem_wdata", mem_wdata, 32'h12345678);
        check("sim_mem_addr", mem_addr, 32'h8000);
        tick();
        check("sim_ls_ack", {31'd0, ls_ack}, 32'd1);
        check("sim_if_ack_c2", {31'd0, if_ack}, 32'd0);
        ls_req = 1'b0;
        tick();
        check("sim_idle_c3", {31'd0, mem_req}, 32'd0);
        mem_rdata = 32'h0BADF00D;
        tick();
        check("sim_if_mem_addr", mem_addr, 32'h200);
        check("sim_if_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        check("sim_if_ack", {31'd0, if_ack}, 32'd1);
        check("sim_if_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        tick();

        // Starvation guard: LS grants show mem_we=1, IF grants mem_we=0
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h9000; ls_be = 4'hF;
        n_grants = 0;
        prev_req = 1'b0;
        grant_we = 6'd0;
        for (int c = 0; c < 40 && n_grants < 6; c++) begin
            tick();
            if (mem_req && !prev_req) begin
                grant_we[n_grants] = mem_we;
                n_grants++;
            end
            prev_req = mem_req;
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("starve_grants", n_grants, 32'd6);
        exp_we = 6'b011011;
        for (int g = 0; g < 6; g++) begin
            check($sformatf("starve_grant%0d", g), {31'd0, grant_we[g]}, {31'd0, exp_we[g]});
        end
        repeat (6) tick();
        auto_rdy = 1'b0;
        check("starve_drain_busy", {31'd0, busy}, 32'd0);

        // Wait states; ready arrives on the last timeout cycle and must win
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_be = 4'hF; rdy_drv = 1'b0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("ws_mem_req_c%0d", c), {31'd0, mem_req}, 32'd1);
            check($sformatf("ws_mem_addr_c%0d", c), mem_addr, 32'h40);
            if (c == 4) begin
                rdy_drv = 1'b1; mem_rdata = 32'hCAFEF00D;
            end
            tick();
        end
        check("ws_ls_ack", {31'd0, ls_ack}, 32'd1);
        check("ws_ls_rdata", ls_rdata, 32'hCAFEF00D);
        check("ws_ls_err", {31'd0, ls_err}, 32'd0);
        ls_req = 1'b0; rdy_drv = 1'b0;
        tick();
        check("ws_ack_pulse", {31'd0, ls_ack}, 32'd0);

        // Timeout with mem_rdy stuck low
        ls_req = 1'b1; ls_addr = 32'h44; mem_rdata = 32'h77777777;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("tmo_mem_req_c%0d", c), {31'd0, mem_req}, 32'd1);
            tick();
        end
        check("tmo_mem_req_off", {31'd0, mem_req}, 32'd0);
        check("tmo_ls_ack", {31'd0, ls_ack}, 32'd1);
        check("tmo_ls_err", {31'd0, ls_err}, 32'd1);
        check("tmo_ls_rdata", ls_rdata, 32'hCAFEF00D);
        ls_req = 1'b0;
        tick();
        check("tmo_err_clear", {30'd0, ls_ack, ls_err}, 32'd0);

        // Reset in the second BUSY cycle of a fetch
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rmid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_if_ack", {31'd0, if_ack}, 32'd0);
        check("rmid_if_rdata", if_rdata, 32'd0);
        check("rmid_ls_rdata", ls_rdata, 32'd0);
        rst = 1'b0;
        tick();
        check("rpost_mem_addr", mem_addr, 32'h300);
        check("rpost_no_ack", {31'd0, if_ack}, 32'd0);
        rdy_drv = 1'b1; mem_rdata = 32'h55AA55AA;
        tick();
        check("rpost_if_ack", {31'd0, if_ack}, 32'd1);
        check("rpost_if_rdata", if_rdata, 32'h55AA55AA);
        if_req = 1'b0;
        tick();

        // mem_rdy outside BUSY is ignored
        tick();
        check("stray_rdy_acks", {30'd0, if_ack, ls_ack}, 32'd0);
        check("stray_rdy_busy", {31'd0, busy}, 32'd0);
        rdy_drv = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
